// File: rtl/esm_pkg.sv
// Shared types and constants for the dependency window and its hazard comparator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package esm_pkg;

    localparam int BS       = 16;
    localparam int BS_BITS  = $clog2(BS);
    localparam int REG_BITS = 5;
    localparam int INSTR_W  = 32;

    // Register 0 is hardwired; it never produces or consumes a real value.
    localparam logic [REG_BITS-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                valid;
        logic [INSTR_W-1:0]  instr;
        logic [REG_BITS-1:0] dest;
        logic [REG_BITS-1:0] src1;
        logic [REG_BITS-1:0] src2;
    } win_entry_t;

endpackage

// File: rtl/hazard_compare.sv
// Pairwise hazard check: does an older entry block a younger one (RAW/WAW/WAR)?
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle for every slot pair.
module hazard_compare
    import esm_pkg::*;
(
    input  logic [REG_BITS-1:0] old_dest,
    input  logic [REG_BITS-1:0] old_src1,
    input  logic [REG_BITS-1:0] old_src2,
    input  logic [REG_BITS-1:0] new_dest,
    input  logic [REG_BITS-1:0] new_src1,
    input  logic [REG_BITS-1:0] new_src2,
    output logic                blocked
);

    logic raw;
    logic waw;
    logic war;

    // A match on register 0 is ignored on whichever side carries it.
    always_comb begin
        raw = (old_dest != ZERO_REG) && ((old_dest == new_src1) || (old_dest == new_src2));
        waw = (new_dest != ZERO_REG) && (old_dest == new_dest);
        war = (new_dest != ZERO_REG) && ((old_src1 == new_dest) || (old_src2 == new_dest));
        blocked = raw || waw || war;
    end

endmodule

// File: rtl/dependency_window.sv
// Instruction window: tracks age and register hazards, publishes hazard-free slots, issues one per cycle.
// Latency: allocation/issue visible one cycle after the edge; issued word appears one cycle after acceptance.
// Backpressure: in_ready drops when all slots are valid; rejected issues pulse issue_error and change nothing.
module dependency_window
    import esm_pkg::*;
#(
    parameter int bs       = BS,
    parameter int reg_bits = REG_BITS,
    parameter int instr_w  = INSTR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [instr_w-1:0]     in_instr,
    input  logic [reg_bits-1:0]    in_dest,
    input  logic [reg_bits-1:0]    in_src1,
    input  logic [reg_bits-1:0]    in_src2,
    input  logic                   issue_valid,
    input  logic [$clog2(bs)-1:0]  issue_index,
    output logic [0:bs-1]          independent_instr,
    output logic [$clog2(bs)-1:0]  buffer_index,
    output logic                   out_valid,
    output logic [instr_w-1:0]     out_instr,
    output logic                   issue_error,
    output logic [$clog2(bs):0]    occupancy
);

    localparam int IW = $clog2(bs);

    win_entry_t          ent   [bs];
    logic [bs-1:0]       older [bs];
    logic [bs-1:0]       valid;
    logic [bs*bs-1:0]    blk;
    logic [0:bs-1]       indep;
    logic [IW-1:0]       free_idx;
    logic [bs-1:0]       issue_mask;
    logic                alloc;
    logic                issue_ok;

    // Gather per-slot valid bits into one vector.
    always_comb begin
        valid = '0;
        for (int i = 0; i < bs; i++) valid[i] = ent[i].valid;
    end

    assign in_ready = ~&valid;
    assign alloc    = in_valid && in_ready;

    // Lowest-numbered free slot from registered state; a slot freed this cycle is not yet free here.
    always_comb begin
        free_idx = '0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (!valid[i]) free_idx = IW'(i);
        end
    end

    // blk[i*bs+j] = older slot j would block younger slot i; diagonal is meaningless and tied off.
    for (genvar i = 0; i < bs; i++) begin : g_row
        for (genvar j = 0; j < bs; j++) begin : g_col
            if (i == j) begin : g_diag
                assign blk[i*bs+j] = 1'b0;
            end else begin : g_cmp
                hazard_compare u_cmp (
                    .old_dest (ent[j].dest),
                    .old_src1 (ent[j].src1),
                    .old_src2 (ent[j].src2),
                    .new_dest (ent[i].dest),
                    .new_src1 (ent[i].src1),
                    .new_src2 (ent[i].src2),
                    .blocked  (blk[i*bs+j])
                );
            end
        end
    end

    // A slot is independent when it is valid and no older resident slot blocks it.
    always_comb begin
        indep = '0;
        for (int i = 0; i < bs; i++) begin
            indep[i] = valid[i] && !(|(blk[i*bs +: bs] & older[i] & valid));
        end
    end

    assign independent_instr = indep;
    assign issue_ok   = issue_valid && indep[issue_index];
    assign issue_mask = issue_ok ? (bs'(1) << issue_index) : '0;

    // Slot storage and age matrix: retire the issued column, then load the newly allocated row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < bs; i++) begin
                ent[i]   <= '0;
                older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < bs; i++) older[i] <= older[i] & ~issue_mask;
            if (issue_ok) ent[issue_index].valid <= 1'b0;
            if (alloc) begin
                ent[free_idx]   <= '{valid: 1'b1, instr: in_instr, dest: in_dest,
                                     src1: in_src1, src2: in_src2};
                older[free_idx] <= valid & ~issue_mask;
            end
        end
    end

    // Issue result, error pulse and occupancy counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buffer_index <= '0;
            out_valid    <= 1'b0;
            out_instr    <= '0;
            issue_error  <= 1'b0;
            occupancy    <= '0;
        end else begin
            out_valid   <= issue_ok;
            issue_error <= issue_valid && !issue_ok;
            if (issue_ok) begin
                buffer_index <= issue_index;
                out_instr    <= ent[issue_index].instr;
            end
            occupancy <= occupancy + (IW+1)'(alloc) - (IW+1)'(issue_ok);
        end
    end

endmodule

// File: tb/tb_dependency_window.sv
module tb_dependency_window;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [4:0]  in_dest;
    logic [4:0]  in_src1;
    logic [4:0]  in_src2;
    logic        issue_valid;
    logic [3:0]  issue_index;
    logic [0:15] independent_instr;
    logic [3:0]  buffer_index;
    logic        out_valid;
    logic [31:0] out_instr;
    logic        issue_error;
    logic [4:0]  occupancy;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  idx;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    dependency_window dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_instr          (in_instr),
        .in_dest           (in_dest),
        .in_src1           (in_src1),
        .in_src2           (in_src2),
        .issue_valid       (issue_valid),
        .issue_index       (issue_index),
        .independent_instr (independent_instr),
        .buffer_index      (buffer_index),
        .out_valid         (out_valid),
        .out_instr         (out_instr),
        .issue_error       (issue_error),
        .occupancy         (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [31:0] w, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2);
        in_valid = 1'b1;
        in_instr = w;
        in_dest  = d;
        in_src1  = s1;
        in_src2  = s2;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_issue(input logic [3:0] idx, input logic [31:0] w);
        q.push_back('{instr: w, idx: idx});
        issue_index = idx;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        chk("issue_ok_no_err", {63'd0, issue_error}, 64'd0);
    endtask

    // Scoreboard: every out_valid pulse must match the oldest expected issue.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_instr", {32'd0, out_instr}, {32'd0, e.instr});
                chk("buffer_index", {60'd0, buffer_index}, {60'd0, e.idx});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_dest = '0; in_src1 = '0; in_src2 = '0;
        issue_valid = 1'b0; issue_index = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_indep", 64'(independent_instr), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_buf_idx", 64'(buffer_index), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_issue_err", 64'(issue_error), 64'd0);
        @(negedge clk) rst = 1'b1;
        tick();
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_occ", 64'(occupancy), 64'd0);
        chk("idle_indep", 64'(independent_instr), 64'd0);

        // A, B (RAW on r1 against A), C
        alloc(32'hAAAA_0001, 5'd1, 5'd2, 5'd3);
        alloc(32'hBBBB_0002, 5'd4, 5'd1, 5'd5);
        alloc(32'hCCCC_0003, 5'd6, 5'd7, 5'd8);
        chk("abc_occ", 64'(occupancy), 64'd3);
        chk("abc_indep", 64'(independent_instr), 64'hA000);

        // B is blocked: rejected, nothing changes
        issue_index = 4'd1;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        chk("rej_issue_err", 64'(issue_error), 64'd1);
        chk("rej_out_valid", 64'(out_valid), 64'd0);
        chk("rej_buf_idx", 64'(buffer_index), 64'd0);
        chk("rej_occ", 64'(occupancy), 64'd3);
        chk("rej_indep", 64'(independent_instr), 64'hA000);
        tick();
        chk("rej_err_pulse", 64'(issue_error), 64'd0);

        // Issue A, then B becomes free
        do_issue(4'd0, 32'hAAAA_0001);
        chk("a_out_valid", 64'(out_valid), 64'd1);
        chk("a_indep", 64'(independent_instr), 64'h6000);
        chk("a_occ", 64'(occupancy), 64'd2);
        do_issue(4'd1, 32'hBBBB_0002);
        do_issue(4'd2, 32'hCCCC_0003);
        chk("drain_occ", 64'(occupancy), 64'd0);
        chk("drain_indep", 64'(independent_instr), 64'd0);

        // Fill all slots with register-0-only entries
        for (int k = 0; k < 16; k++) alloc(32'h100 + 32'(k), 5'd0, 5'd0, 5'd0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_occ", 64'(occupancy), 64'd16);
        chk("full_indep", 64'(independent_instr), 64'hFFFF);
        alloc(32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0);
        chk("full_ignore_occ", 64'(occupancy), 64'd16);

        // Issue slot 5 with in_valid held: not refilled this cycle, refilled next
        q.push_back('{instr: 32'h105, idx: 4'd5});
        issue_index = 4'd5;
        issue_valid = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h0000_0555;
        tick();
        issue_valid = 1'b0;
        chk("s5_occ", 64'(occupancy), 64'd15);
        chk("s5_indep", 64'(independent_instr), 64'hFBFF);
        chk("s5_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("s5_refill_occ", 64'(occupancy), 64'd16);
        chk("s5_refill_indep", 64'(independent_instr), 64'hFFFF);

        // Free slot 10, then issue slot 2 while allocating: new entry lands in 10, not 2
        do_issue(4'd10, 32'h10A);
        chk("s10_occ", 64'(occupancy), 64'd15);
        q.push_back('{instr: 32'h102, idx: 4'd2});
        issue_index = 4'd2;
        issue_valid = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h0000_AAA0;
        tick();
        issue_valid = 1'b0;
        in_valid = 1'b0;
        chk("sim_occ", 64'(occupancy), 64'd15);
        chk("sim_indep", 64'(independent_instr), 64'hDFFF);
        alloc(32'h0000_BBB0, 5'd0, 5'd0, 5'd0);
        chk("sim_refill_occ", 64'(occupancy), 64'd16);
        do_issue(4'd10, 32'h0000_AAA0);
        do_issue(4'd2, 32'h0000_BBB0);
        do_issue(4'd5, 32'h0000_0555);
        chk("post_occ", 64'(occupancy), 64'd13);

        // Asynchronous reset while an out_valid pulse is showing
        issue_index = 4'd1;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        chk("pre_rst_buf_idx", 64'(buffer_index), 64'd1);
        #1 rst = 1'b0;
        #1;
        chk("arst_occ", 64'(occupancy), 64'd0);
        chk("arst_indep", 64'(independent_instr), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_buf_idx", 64'(buffer_index), 64'd0);
        chk("arst_out_instr", 64'(out_instr), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk) rst = 1'b1;
        tick();

        // Hazard mix: WAR (Q), WAW (R), RAW via src2 (S), register 0 only (T)
        alloc(32'h0000_00F0, 5'd2, 5'd5, 5'd6);
        alloc(32'h0000_00F1, 5'd5, 5'd0, 5'd0);
        alloc(32'h0000_00F2, 5'd2, 5'd0, 5'd0);
        alloc(32'h0000_00F3, 5'd0, 5'd0, 5'd2);
        alloc(32'h0000_00F4, 5'd0, 5'd0, 5'd0);
        chk("hz_occ", 64'(occupancy), 64'd5);
        chk("hz_indep", 64'(independent_instr), 64'h8800);
        do_issue(4'd0, 32'h0000_00F0);
        chk("hz_after_p_indep", 64'(independent_instr), 64'h6800);

        tick();
        tick();
        chk("scoreboard_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dependency_window.md
Name: dependency_window

Overview:
- Upstream neighbour of the ESM core.
- Holds up to bs in-flight instructions, each tagged with destination and source register fields.
- Each cycle it publishes the independent_instr bitmap of entries that have no hazard against any older resident entry.
- It accepts the core's selected slot (next_buffer_index, qualified by valid_count), retires that entry, emits its instruction word, and reports the issued slot back as buffer_index.

Parameters:
- bs, 16, number of window slots; power of two, ≥ 2.
- reg_bits, 5, width of a register specifier.
- instr_w, 32, width of the stored instruction word.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  allocation request.
- in_ready  output  1  at least one free slot.
- in_instr  input  instr_w  instruction word to store.
- in_dest  input  reg_bits  destination register.
- in_src1  input  reg_bits  source register 1.
- in_src2  input  reg_bits  source register 2.
- issue_valid  input  1  issue strobe (driven from the core's valid_count).
- issue_index  input  $clog2(bs)  slot to issue (driven from next_buffer_index).
- independent_instr  output  [0:bs-1]  bit i = slot i is valid and hazard-free.
- buffer_index  output  $clog2(bs)  slot index of the last accepted issue.
- out_valid  output  1  one-cycle pulse: out_instr holds an issued word.
- out_instr  output  instr_w  issued instruction word.
- issue_error  output  1  one-cycle pulse: an issue request was rejected.
- occupancy  output  $clog2(bs)+1  number of valid slots.

Behaviour:
- Reset (rst low, asynchronous):
  - all valid bits, age matrix and occupancy cleared;
  - independent_instr = 0, buffer_index = 0, out_valid = 0, out_instr = 0, issue_error = 0;
  - in_ready = 1 once reset is released.
- Per-slot state: valid, instr, dest, src1, src2, and an age row older[i][0:bs-1]. older[i][j] = 1 means slot j entered before slot i and is still resident.
- Allocation:
  - Happens when in_valid && in_ready.
  - The target is the lowest-numbered slot that is free in the current registered state.
  - At the clock edge: the slot's valid is set, its fields are written, and older[slot] is loaded with the current valid vector minus any slot issued in the same cycle.
- in_ready = !(&valid). It is computed combinationally from registered state.
- Hazard rule: slot i is blocked by older valid slot j if any of the following holds:
  - RAW: dest_j == src1_i or dest_j == src2_i;
  - WAW: dest_j == dest_i;
  - WAR: src1_j == dest_i or src2_j == dest_i.
  - Register 0 never creates a hazard.
- independent_instr[i] = valid_i && no blocking j. It is combinational from registered state, so it reflects an allocation or issue one cycle after the edge.
- Issue:
  - Accepted when issue_valid && valid[issue_index] && independent_instr[issue_index].
  - At the clock edge: valid[issue_index] is cleared, column issue_index is cleared in every age row, buffer_index <= issue_index, out_instr <= stored word, out_valid = 1 for one cycle. Latency is one cycle.
- Rejected issue:
  - Occurs when the slot is empty or not independent.
  - State is unchanged and buffer_index holds its value; issue_error pulses for one cycle and out_valid stays 0.
- Simultaneous allocation and issue in the same cycle:
  - Both take effect.
  - The freed slot is not reused in that cycle; it becomes allocatable the next cycle.
  - occupancy is unchanged.
- Full window: in_valid with in_ready = 0 is ignored and the stored data is not touched.
- Empty window: independent_instr = 0 and occupancy = 0.
- occupancy is registered and saturates naturally at bs; it never wraps.
- Reset mid-operation discards all entries. Any out_valid pulse pending is cancelled.

Decomposition:
- A shared package (esm_pkg) holds:
  - the window-entry struct typedef (valid, instr, dest, src1, src2);
  - localparam BS_BITS = $clog2(bs);
  - the ZERO_REG constant.
- One sub-module, hazard_compare: a combinational pairwise check (older entry vs younger entry) returning blocked. It is instantiated bs×bs under generate, with the diagonal tied to 0.

Test Plan:
- Reset, then idle: occupancy = 0, independent_instr = 16'h0000, in_ready = 1, out_valid = 0.
- Allocate A(dest=1, src=2,3), B(dest=4, src=1,5), C(dest=6, src=7,8) → slots 0, 1, 2; independent_instr = 1010_0000…; B is blocked by RAW on r1.
- Issue index 0 → next cycle: out_valid = 1, out_instr = A, buffer_index = 0; independent_instr = 0110_0000…; occupancy = 2.
- Issue index 1 while B is still blocked (before A issues) → issue_error = 1, state unchanged, buffer_index unchanged.
- Fill all 16 slots with dest=0 → in_ready = 0, all independent. Extra in_valid is ignored. Issue slot 5 together with in_valid → slot 5 is not refilled that cycle and is refilled the following cycle.
- Assert rst low asynchronously mid-stream → all outputs return to reset values immediately, before the next edge.
